// File: rtl/pipe_addsub_pkg.sv
// Shared types and legal parameter ranges for the pipe_addsub add/subtract pipeline.
package pipe_addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int WIDTH_MIN  = 4;
  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

endpackage

// File: rtl/pipe_addsub_stage.sv
// One pipeline register: data + valid, advancing on adv_i and holding otherwise.
module pipe_addsub_stage #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv_i,
  input  logic          vld_i,
  input  logic [DW-1:0] dat_i,
  output logic          vld_o,
  output logic [DW-1:0] dat_o
);

  logic          vld_q;
  logic [DW-1:0] dat_q;

  // Data only loads on a real operation so bubbles leave the last result in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (adv_i) begin
      vld_q <= vld_i;
      if (vld_i) dat_q <= dat_i;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined unsigned add/subtract with carry/borrow and signed overflow flag.
// Define PIPE_ADDSUB_SATURATE_EN to clamp the low WIDTH result bits on signed overflow.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             out_ovf
);

  localparam int DW = WIDTH + 2;

  op_e                     op;
  logic [WIDTH:0]          raw;
  logic                    sa, sb, sr, ovf;
  logic [WIDTH-1:0]        lo;
  logic [DW-1:0]           res_d;
  logic                    stall, adv;
  logic                    s1_vld_q;
  logic [DW-1:0]           s1_dat_q;
  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0][DW-1:0] dat_pipe;

  // Stage-1 arithmetic; the WIDTH+1-bit unsigned difference carries the borrow in its MSB.
  assign op  = op_e'(in_op);
  assign raw = (op == OP_SUB) ? ({1'b0, in1} - {1'b0, in2}) : ({1'b0, in1} + {1'b0, in2});
  assign sa  = in1[WIDTH-1];
  assign sb  = in2[WIDTH-1];
  assign sr  = raw[WIDTH-1];
  assign ovf = (op == OP_SUB) ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));

`ifdef PIPE_ADDSUB_SATURATE_EN
  // On overflow the true result always has in1's sign.
  assign lo = !ovf ? raw[WIDTH-1:0]
            : sa   ? {1'b1, {(WIDTH-1){1'b0}}}
            :        {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign lo = raw[WIDTH-1:0];
`endif

  assign res_d = {ovf, raw[WIDTH], lo};

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = res_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else if (adv) begin
      s1_vld_q <= vld_pipe[0];
      if (vld_pipe[0]) s1_dat_q <= dat_pipe[0];
    end
  end

  assign vld_pipe[1] = s1_vld_q;
  assign dat_pipe[1] = s1_dat_q;

  for (genvar s = 2; s <= STAGES; s++) begin : g_stage
    pipe_addsub_stage #(.DW(DW)) u_stage (
      .clk   (clk),
      .reset (reset),
      .adv_i (adv),
      .vld_i (vld_pipe[s-1]),
      .dat_i (dat_pipe[s-1]),
      .vld_o (vld_pipe[s]),
      .dat_o (dat_pipe[s])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign out       = dat_pipe[STAGES][WIDTH:0];
  assign out_ovf   = dat_pipe[STAGES][WIDTH+1];

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed table and corner sequences at 8/2, random scoreboard run at 16/4.
module tb_pipe_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed overflow judged on true integer values, not on bit patterns.
  function automatic void ref_op(input int w, input bit op, input int a, input int b,
                                 output int r, output bit ovf);
    int half, full, sa, sb, sr;
    half = 1 << (w - 1);
    full = 1 << w;
    sa   = (a >= half) ? a - full : a;
    sb   = (b >= half) ? b - full : b;
    sr   = op ? sa - sb : sa + sb;
    ovf  = (sr >= half) || (sr < -half);
    if (op) r = ((a - b + full) % full) + ((a < b) ? full : 0);
    else    r = a + b;
`ifdef PIPE_ADDSUB_SATURATE_EN
    if (ovf) r = (r & full) | ((sr < 0) ? half : half - 1);
`endif
  endfunction

  // DUT A: WIDTH=8, STAGES=2
  logic       a_rst, a_iv, a_ir, a_op, a_ov, a_or, a_ovf;
  logic [7:0] a_in1, a_in2;
  logic [8:0] a_out;

  pipe_addsub #(.WIDTH(8), .STAGES(2)) u_a (
    .clk(clk), .reset(a_rst), .in_valid(a_iv), .in_ready(a_ir), .in_op(a_op),
    .in1(a_in1), .in2(a_in2), .out_valid(a_ov), .out_ready(a_or), .out(a_out), .out_ovf(a_ovf)
  );

  // DUT B: WIDTH=16, STAGES=4
  logic        b_rst, b_iv, b_ir, b_op, b_ov, b_or, b_ovf;
  logic [15:0] b_in1, b_in2;
  logic [16:0] b_out;

  pipe_addsub #(.WIDTH(16), .STAGES(4)) u_b (
    .clk(clk), .reset(b_rst), .in_valid(b_iv), .in_ready(b_ir), .in_op(b_op),
    .in1(b_in1), .in2(b_in2), .out_valid(b_ov), .out_ready(b_or), .out(b_out), .out_ovf(b_ovf)
  );

  typedef struct {
    bit op;
    int a;
    int b;
    int r;
    bit ovf;
  } vec_t;

  typedef struct {
    int r;
    bit ovf;
    int acyc;
    int astall;
    bit seen;
  } sb_t;

  function automatic int pick16();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  vec_t tbl[9];

  initial begin
    int       lat, sent, prev, r;
    bit       o;
    logic [8:0] got[$];
    sb_t      q[$];
    int       n_acc, cyc, stalls, ra, rb;
    bit       rop, stall;
    logic [16:0] last_out;
    logic     last_ovf;

    tbl[0] = '{1'b0, 200, 100, 'h12C, 1'b0};
    tbl[1] = '{1'b1, 5, 10, 'h1FB, 1'b0};
    tbl[2] = '{1'b0, 'hFF, 'hFF, 'h1FE, 1'b0};
    tbl[3] = '{1'b1, 0, 0, 'h000, 1'b0};
    tbl[4] = '{1'b1, 'hFF, 'h01, 'h0FE, 1'b0};
`ifdef PIPE_ADDSUB_SATURATE_EN
    tbl[5] = '{1'b1, 'h80, 'h01, 'h080, 1'b1};
    tbl[6] = '{1'b0, 'h7F, 'h01, 'h07F, 1'b1};
    tbl[7] = '{1'b0, 'h80, 'h80, 'h180, 1'b1};
    tbl[8] = '{1'b1, 'h7F, 'hFF, 'h17F, 1'b1};
`else
    tbl[5] = '{1'b1, 'h80, 'h01, 'h07F, 1'b1};
    tbl[6] = '{1'b0, 'h7F, 'h01, 'h080, 1'b1};
    tbl[7] = '{1'b0, 'h80, 'h80, 'h100, 1'b1};
    tbl[8] = '{1'b1, 'h7F, 'hFF, 'h180, 1'b1};
`endif

    a_rst = 1'b1; a_iv = 1'b0; a_op = 1'b0; a_in1 = '0; a_in2 = '0; a_or = 1'b1;
    b_rst = 1'b1; b_iv = 1'b0; b_op = 1'b0; b_in1 = '0; b_in2 = '0; b_or = 1'b1;
    #1;
    chk("rst_out_valid", a_ov, 0);
    chk("rst_out", a_out, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_in_ready", a_ir, 1);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    #1 chk("rel_in_ready", a_ir, 1);
    @(posedge clk); #1;

    // Directed table: latency, value, and hold-while-invalid
    prev = 0;
    for (int i = 0; i < 9; i++) begin
      a_iv = 1'b1; a_op = tbl[i].op; a_in1 = tbl[i].a[7:0]; a_in2 = tbl[i].b[7:0];
      @(posedge clk); #1;
      a_iv = 1'b0;
      lat = 1;
      if (i > 0) chk($sformatf("hold_%0d", i), a_out, prev);
      while (!a_ov && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("lat_%0d", i), lat, 2);
      chk($sformatf("out_%0d", i), a_out, tbl[i].r);
      chk($sformatf("ovf_%0d", i), a_ovf, tbl[i].ovf);
      prev = tbl[i].r;
    end
    repeat (3) begin @(posedge clk); #1; end

    // Back-to-back stream of 8 adds, downstream stalled in cycles 3..5
    sent = 0;
    for (int c = 0; c < 40 && got.size() < 8; c++) begin
      a_or  = !(c >= 3 && c <= 5);
      a_iv  = (sent < 8);
      a_op  = 1'b0;
      a_in1 = 8'(sent * 17 + 3);
      a_in2 = 8'(sent * 29 + 150);
      #1;
      chk("stream_ready", a_ir, !(a_ov && !a_or));
      if (c >= 3 && c <= 5) chk("stream_stalled_ready", a_ir, 0);
      if (a_ov && a_or) got.push_back(a_out);
      if (a_iv && a_ir) sent++;
      @(posedge clk); #1;
    end
    a_iv = 1'b0; a_or = 1'b1;
    chk("stream_count", got.size(), 8);
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      ref_op(8, 1'b0, (k * 17 + 3) % 256, (k * 29 + 150) % 256, r, o);
      chk($sformatf("stream_%0d", k), got[k], r);
    end
    repeat (3) begin @(posedge clk); #1; end

    // Reset with two operations in flight
    a_iv = 1'b1; a_op = 1'b0; a_in1 = 8'd20; a_in2 = 8'd30;
    @(posedge clk); #1;
    a_in1 = 8'd40; a_in2 = 8'd50;
    @(posedge clk); #1;
    a_iv = 1'b0;
    a_rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", a_ov, 0);
    chk("mid_rst_out", a_out, 0);
    chk("mid_rst_ovf", a_ovf, 0);
    @(negedge clk);
    a_rst = 1'b0;
    #1 chk("mid_rel_in_ready", a_ir, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("no_stale", a_ov, 0);
    end

    // Random run at WIDTH=16, STAGES=4 against the scoreboard
    n_acc = 0; cyc = 0; stalls = 0; last_out = '0; last_ovf = 1'b0;
    while ((n_acc < 10000 || q.size() > 0) && cyc < 60000) begin
      if (n_acc < 10000) begin
        b_iv  = ($urandom_range(0, 99) < 85);
        b_op  = 1'($urandom_range(0, 1));
        b_in1 = 16'(pick16());
        b_in2 = 16'(pick16());
        b_or  = ($urandom_range(0, 9) < 7);
      end else begin
        b_iv = 1'b0;
        b_or = 1'b1;
      end
      #1;
      stall = b_ov && !b_or;
      chk("b_ready", b_ir, !stall);
      if (b_ov) begin
        if (q.size() == 0) chk("b_spurious_valid", 1, 0);
        else begin
          if (!q[0].seen) begin
            chk("b_latency", cyc - q[0].acyc - (stalls - q[0].astall), 4);
            q[0].seen = 1'b1;
          end
          chk("b_out", b_out, q[0].r);
          chk("b_ovf", b_ovf, q[0].ovf);
          if (b_or) void'(q.pop_front());
        end
        last_out = b_out;
        last_ovf = b_ovf;
      end else begin
        chk("b_hold_out", b_out, last_out);
        chk("b_hold_ovf", b_ovf, last_ovf);
      end
      if (b_iv && b_ir) begin
        ra = int'(b_in1); rb = int'(b_in2); rop = b_op;
        ref_op(16, rop, ra, rb, r, o);
        q.push_back('{r, o, cyc, stalls, 1'b0});
        n_acc++;
      end
      if (stall) stalls++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("b_accepted", n_acc, 10000);
    chk("b_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
